// File: rtl/reg_write_arbiter.sv
// rtl/reg_write_arbiter.sv - round-robin write arbiter for the register bank write port (optional burst lock: ARB_LOCK_EN)
module reg_write_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 16,
  parameter int MAX_LOCK = 8
) (
  input  logic                      inClk,
  input  logic                      inClr,
  input  logic [NUM_REQ-1:0]        inReq,
  input  logic [NUM_REQ*ADDR_W-1:0] inAddr,
  input  logic [NUM_REQ*DATA_W-1:0] inData,
  input  logic [NUM_REQ-1:0]        inLock,
  output logic [NUM_REQ-1:0]        outGnt,
  output logic                      outWrEn,
  output logic [ADDR_W-1:0]         outWrAddr,
  output logic [DATA_W-1:0]         outWrData,
  output logic                      outLocked
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IDX_W-1:0] LAST_REQ = IDX_W'(NUM_REQ - 1);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } stateT;

  stateT            state;
  stateT            stateNxt;
  logic [IDX_W-1:0] lastIdx;
  logic [IDX_W-1:0] lastIdxNxt;

  // Round-robin search result
  logic             found;
  logic [IDX_W-1:0] winIdx;
  int               rrIdx;

  // Grant selection for the coming edge
  logic             doGrant;
  logic             arbitrate;
  logic [IDX_W-1:0] selIdx;

  logic [NUM_REQ-1:0] gntNxt;
  logic               wrEnNxt;
  logic [ADDR_W-1:0]  wrAddrNxt;
  logic [DATA_W-1:0]  wrDataNxt;

`ifdef ARB_LOCK_EN
  localparam logic [7:0] LOCK_MAX = 8'(MAX_LOCK);
  logic [7:0] lockCnt;
  logic [7:0] lockCntNxt;
`else
  // Lock inputs have no effect in this build; keep them visibly consumed.
  logic unusedLock;
  assign unusedLock = ^{inLock, 8'(MAX_LOCK)};
`endif

  // Find the first requester after the last winner, wrapping around
  always_comb begin
    found  = 1'b0;
    winIdx = lastIdx;
    rrIdx  = 0;
    for (int j = 1; j <= NUM_REQ; j++) begin
      rrIdx = (int'(lastIdx) + j) % NUM_REQ;
      if (!found && inReq[IDX_W'(rrIdx)]) begin
        found  = 1'b1;
        winIdx = IDX_W'(rrIdx);
      end
    end
  end

  // Next-state, pointer, lock count and registered-output values
  always_comb begin
    stateNxt   = state;
    lastIdxNxt = lastIdx;
    doGrant    = 1'b0;
    arbitrate  = 1'b0;
    selIdx     = lastIdx;
`ifdef ARB_LOCK_EN
    lockCntNxt = lockCnt;
`endif

    case (state)
      IDLE: arbitrate = 1'b1;
`ifdef ARB_LOCK_EN
      LOCKED: begin
        if (lockCnt == LOCK_MAX) begin
          // Burst exhausted: this edge is an ordinary round-robin edge
          // starting after the owner, so the owner ranks lowest.
          stateNxt  = IDLE;
          arbitrate = 1'b1;
        end else begin
          // Only the owner can write; an owner idle cycle still uses up
          // one slot of the burst.
          if (inReq[lastIdx]) begin
            doGrant = 1'b1;
            selIdx  = lastIdx;
          end
          if (!inLock[lastIdx]) begin
            stateNxt = IDLE;
          end else begin
            lockCntNxt = lockCnt + 8'd1;
          end
        end
      end
`endif
      default: stateNxt = IDLE;
    endcase

    if (arbitrate && found) begin
      doGrant    = 1'b1;
      selIdx     = winIdx;
      lastIdxNxt = winIdx;
`ifdef ARB_LOCK_EN
      if (inLock[winIdx]) begin
        stateNxt   = LOCKED;
        lockCntNxt = 8'd1;
      end
`endif
    end

    // Address/data hold their last value when no write is issued.
    gntNxt    = '0;
    wrEnNxt   = doGrant;
    wrAddrNxt = outWrAddr;
    wrDataNxt = outWrData;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (doGrant && (selIdx == IDX_W'(i))) begin
        gntNxt[i] = 1'b1;
        wrAddrNxt = inAddr[i*ADDR_W +: ADDR_W];
        wrDataNxt = inData[i*DATA_W +: DATA_W];
      end
    end
  end

  // State, pointer and write-port registers; reset drops any in-flight write
  always_ff @(posedge inClk or posedge inClr) begin
    if (inClr) begin
      state     <= IDLE;
      lastIdx   <= LAST_REQ;
      outGnt    <= '0;
      outWrEn   <= 1'b0;
      outWrAddr <= '0;
      outWrData <= '0;
    end else begin
      state     <= stateNxt;
      lastIdx   <= lastIdxNxt;
      outGnt    <= gntNxt;
      outWrEn   <= wrEnNxt;
      outWrAddr <= wrAddrNxt;
      outWrData <= wrDataNxt;
    end
  end

`ifdef ARB_LOCK_EN
  // Burst length counter, meaningful only while LOCKED
  always_ff @(posedge inClk or posedge inClr) begin
    if (inClr) begin
      lockCnt <= 8'd0;
    end else begin
      lockCnt <= lockCntNxt;
    end
  end

  assign outLocked = (state == LOCKED);
`else
  assign outLocked = 1'b0;
`endif

endmodule
